// File: rtl/img_pkg.sv
// Shared definitions for the luma-plane image pipeline stages.
package img_pkg;

  localparam int PIX_W         = 8;
  localparam int IMG_HDISP_DEF = 640;
  localparam int IMG_VDISP_DEF = 480;

  typedef logic [PIX_W-1:0] pix_t;

  localparam pix_t PIX_ZERO = 8'd0;

  // Zero-padding helper: keep the pixel when the neighbour exists, else 0.
  function automatic pix_t pix_mask(input pix_t pix, input logic keep);
    pix_t res;
    if (keep) begin
      res = pix;
    end else begin
      res = PIX_ZERO;
    end
    return res;
  endfunction

endpackage

// File: rtl/line_buffer_ram.sv
// Simple dual-port line buffer: one write port, one registered read port.
// A read and a write to the same address in one cycle return the old data.
module line_buffer_ram
  import img_pkg::*;
#(
  parameter int DEPTH  = IMG_HDISP_DEF,
  parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PIX_W-1:0]  rd_data
);

  pix_t mem_r [DEPTH];

  // Storage array write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Registered read port; sees the array before this cycle's write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= PIX_ZERO;
    end else if (rd_en) begin
      rd_data <= mem_r[rd_addr];
    end else begin
      rd_data <= rd_data;
    end
  end

endmodule

// File: rtl/y_matrix_3x3.sv
// Streaming 3x3 luma neighbourhood generator. The window is bottom-right
// anchored: p33 is the newest pixel, p11 is two lines up and two columns left.
// Missing neighbours at the top and left borders are zero padded.
module y_matrix_3x3
  import img_pkg::*;
#(
  parameter int IMG_HDISP = IMG_HDISP_DEF,
  parameter int IMG_VDISP = IMG_VDISP_DEF
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             per_img_vsync,
  input  logic             per_img_href,
  input  logic [PIX_W-1:0] per_img_Y,
  output logic             matrix_img_vsync,
  output logic             matrix_img_href,
  output logic [PIX_W-1:0] matrix_p11,
  output logic [PIX_W-1:0] matrix_p12,
  output logic [PIX_W-1:0] matrix_p13,
  output logic [PIX_W-1:0] matrix_p21,
  output logic [PIX_W-1:0] matrix_p22,
  output logic [PIX_W-1:0] matrix_p23,
  output logic [PIX_W-1:0] matrix_p31,
  output logic [PIX_W-1:0] matrix_p32,
  output logic [PIX_W-1:0] matrix_p33
);

  localparam int COL_W = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
  localparam int ROW_W = (IMG_VDISP > 1) ? $clog2(IMG_VDISP) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_HDISP - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_VDISP - 1);

  logic             href_d1_r;
  logic             vsync_d1_r;
  logic             frame_act_r;
  logic             wr_en_s;
  logic             wr_en_d1_r;
  logic             byp_s;
  logic             byp_en_r;
  logic             vsync_rise_s;
  logic             href_fall_s;
  logic             keep1_s;
  logic             keep2_s;
  logic [COL_W-1:0] col_s;
  logic [COL_W-1:0] col_r;
  logic [ROW_W-1:0] row_r;
  logic [ROW_W-1:0] row_d1_r;
  pix_t             y_d1_r;
  pix_t             byp_data_r;
  pix_t             buf1_q_s;
  pix_t             buf2_q_s;
  pix_t             buf2_eff_s;
  pix_t             top_s;
  pix_t             mid_s;

  assign vsync_rise_s = per_img_vsync & ~vsync_d1_r;
  assign href_fall_s  = href_d1_r & ~per_img_href;

  // Column of the pixel on the input and whether it may enter the line buffers.
  always_comb begin
    col_s   = '0;
    wr_en_s = 1'b0;
    if (!per_img_href) begin
      col_s   = '0;
      wr_en_s = 1'b0;
    end else if (!href_d1_r) begin
      col_s   = '0;
      wr_en_s = 1'b1;
    end else if (col_r == COL_LAST) begin
      col_s   = COL_LAST;
      wr_en_s = 1'b0;
    end else begin
      col_s   = col_r + COL_W'(1'b1);
      wr_en_s = 1'b1;
    end
  end

  // buf2 is written one cycle late; forward that pending write to a same-address read.
  always_comb begin
    byp_s = 1'b0;
    if (per_img_href && wr_en_d1_r && (col_s == col_r)) begin
      byp_s = 1'b1;
    end else begin
      byp_s = 1'b0;
    end
  end

  // Input-side delay registers: sync history, column, pixel and pending buf2 write.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      href_d1_r  <= 1'b0;
      vsync_d1_r <= 1'b0;
      col_r      <= '0;
      row_d1_r   <= '0;
      y_d1_r     <= PIX_ZERO;
      wr_en_d1_r <= 1'b0;
      byp_en_r   <= 1'b0;
      byp_data_r <= PIX_ZERO;
    end else begin
      href_d1_r  <= per_img_href;
      vsync_d1_r <= per_img_vsync;
      col_r      <= col_s;
      row_d1_r   <= row_r;
      y_d1_r     <= per_img_Y;
      wr_en_d1_r <= wr_en_s;
      byp_en_r   <= byp_s;
      byp_data_r <= buf1_q_s;
    end
  end

  // Row counter: restarts on a vsync rising edge, counts line ends, and stays
  // at 0 after reset until the first vsync edge marks a real frame start.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      row_r       <= '0;
      frame_act_r <= 1'b0;
    end else if (vsync_rise_s) begin
      row_r       <= '0;
      frame_act_r <= 1'b1;
    end else if (frame_act_r && href_fall_s && (row_r != ROW_LAST)) begin
      row_r       <= row_r + ROW_W'(1'b1);
      frame_act_r <= frame_act_r;
    end else begin
      row_r       <= row_r;
      frame_act_r <= frame_act_r;
    end
  end

  // buf1 holds line N-1: written directly with the incoming pixel.
  line_buffer_ram #(
    .DEPTH  (IMG_HDISP),
    .ADDR_W (COL_W)
  ) u_buf1 (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .wr_en   (wr_en_s),
    .wr_addr (col_s),
    .wr_data (per_img_Y),
    .rd_en   (per_img_href),
    .rd_addr (col_s),
    .rd_data (buf1_q_s)
  );

  // buf2 holds line N-2: written with buf1's read-out as soon as it arrives.
  line_buffer_ram #(
    .DEPTH  (IMG_HDISP),
    .ADDR_W (COL_W)
  ) u_buf2 (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .wr_en   (wr_en_d1_r),
    .wr_addr (col_r),
    .wr_data (buf1_q_s),
    .rd_en   (per_img_href),
    .rd_addr (col_s),
    .rd_data (buf2_q_s)
  );

  // New window column with top-border masking, plus left-border keep flags.
  always_comb begin
    buf2_eff_s = buf2_q_s;
    if (byp_en_r) begin
      buf2_eff_s = byp_data_r;
    end else begin
      buf2_eff_s = buf2_q_s;
    end
    top_s   = pix_mask(buf2_eff_s, (32'(row_d1_r) >= 32'd2));
    mid_s   = pix_mask(buf1_q_s,   (32'(row_d1_r) >= 32'd1));
    keep1_s = (32'(col_r) >= 32'd1);
    keep2_s = (32'(col_r) >= 32'd2);
  end

  // Window shift register; clears whenever no pixel is flowing.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      matrix_p11 <= PIX_ZERO;
      matrix_p12 <= PIX_ZERO;
      matrix_p13 <= PIX_ZERO;
      matrix_p21 <= PIX_ZERO;
      matrix_p22 <= PIX_ZERO;
      matrix_p23 <= PIX_ZERO;
      matrix_p31 <= PIX_ZERO;
      matrix_p32 <= PIX_ZERO;
      matrix_p33 <= PIX_ZERO;
    end else if (href_d1_r) begin
      matrix_p11 <= pix_mask(matrix_p12, keep2_s);
      matrix_p12 <= pix_mask(matrix_p13, keep1_s);
      matrix_p13 <= top_s;
      matrix_p21 <= pix_mask(matrix_p22, keep2_s);
      matrix_p22 <= pix_mask(matrix_p23, keep1_s);
      matrix_p23 <= mid_s;
      matrix_p31 <= pix_mask(matrix_p32, keep2_s);
      matrix_p32 <= pix_mask(matrix_p33, keep1_s);
      matrix_p33 <= y_d1_r;
    end else begin
      matrix_p11 <= PIX_ZERO;
      matrix_p12 <= PIX_ZERO;
      matrix_p13 <= PIX_ZERO;
      matrix_p21 <= PIX_ZERO;
      matrix_p22 <= PIX_ZERO;
      matrix_p23 <= PIX_ZERO;
      matrix_p31 <= PIX_ZERO;
      matrix_p32 <= PIX_ZERO;
      matrix_p33 <= PIX_ZERO;
    end
  end

  // Output sync, aligned with the window.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      matrix_img_vsync <= 1'b0;
      matrix_img_href  <= 1'b0;
    end else begin
      matrix_img_vsync <= vsync_d1_r;
      matrix_img_href  <= href_d1_r;
    end
  end

endmodule

// File: tb/tb_y_matrix_3x3.sv
// Self-checking bench for y_matrix_3x3 with a small image (8 x 4).
module tb_y_matrix_3x3;

  localparam int H = 8;
  localparam int V = 4;

  logic       sys_clk       = 1'b0;
  logic       sys_rst       = 1'b1;
  logic       per_img_vsync = 1'b0;
  logic       per_img_href  = 1'b0;
  logic [7:0] per_img_Y     = 8'd0;
  logic       matrix_img_vsync;
  logic       matrix_img_href;
  logic [7:0] matrix_p11, matrix_p12, matrix_p13;
  logic [7:0] matrix_p21, matrix_p22, matrix_p23;
  logic [7:0] matrix_p31, matrix_p32, matrix_p33;

  always #5 sys_clk = ~sys_clk;

  y_matrix_3x3 #(
    .IMG_HDISP (H),
    .IMG_VDISP (V)
  ) dut (
    .sys_clk          (sys_clk),
    .sys_rst          (sys_rst),
    .per_img_vsync    (per_img_vsync),
    .per_img_href     (per_img_href),
    .per_img_Y        (per_img_Y),
    .matrix_img_vsync (matrix_img_vsync),
    .matrix_img_href  (matrix_img_href),
    .matrix_p11       (matrix_p11),
    .matrix_p12       (matrix_p12),
    .matrix_p13       (matrix_p13),
    .matrix_p21       (matrix_p21),
    .matrix_p22       (matrix_p22),
    .matrix_p23       (matrix_p23),
    .matrix_p31       (matrix_p31),
    .matrix_p32       (matrix_p32),
    .matrix_p33       (matrix_p33)
  );

  // Model state: previous two lines as plain arrays, window as a 3x3 array.
  logic [7:0] m_mem1 [H];
  logic [7:0] m_mem2 [H];
  logic [7:0] m_win    [3][3];
  logic [7:0] pend_win [3][3];
  logic [7:0] exp_win  [3][3];
  logic       pend_href, pend_vs, exp_href, exp_vs;
  logic       m_href_prev, m_vs_prev, m_synced;
  int         m_px, m_row, m_c;
  logic [7:0] m_top, m_mid;

  int n_cmp, n_err, ncyc, in_rise, out_rise;
  logic in_prev, out_prev;
  logic [71:0] cap_q [$];

  wire [71:0] dut_pix = {matrix_p11, matrix_p12, matrix_p13,
                         matrix_p21, matrix_p22, matrix_p23,
                         matrix_p31, matrix_p32, matrix_p33};
  wire [73:0] dut_vec = {matrix_img_vsync, matrix_img_href, dut_pix};
  wire [73:0] exp_vec = {exp_vs, exp_href,
                         exp_win[0][0], exp_win[0][1], exp_win[0][2],
                         exp_win[1][0], exp_win[1][1], exp_win[1][2],
                         exp_win[2][0], exp_win[2][1], exp_win[2][2]};

  // One model step per clock: what the window must hold one edge later.
  task automatic model_step();
    if (sys_rst) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          m_win[i][j] = 8'd0; pend_win[i][j] = 8'd0; exp_win[i][j] = 8'd0;
        end
      end
      pend_href = 1'b0; pend_vs = 1'b0; exp_href = 1'b0; exp_vs = 1'b0;
      m_href_prev = 1'b0; m_vs_prev = 1'b0; m_synced = 1'b0;
      m_px = 0; m_row = 0;
    end else begin
      exp_win = pend_win; exp_href = pend_href; exp_vs = pend_vs;
      if (per_img_href) begin
        m_px  = m_href_prev ? m_px + 1 : 0;
        m_c   = (m_px < H) ? m_px : H - 1;
        m_top = (m_row >= 2) ? m_mem2[m_c] : 8'd0;
        m_mid = (m_row >= 1) ? m_mem1[m_c] : 8'd0;
        if (m_px < H) begin
          m_mem2[m_c] = m_mem1[m_c];
          m_mem1[m_c] = per_img_Y;
        end
        for (int i = 0; i < 3; i++) begin
          m_win[i][0] = (m_c >= 2) ? m_win[i][1] : 8'd0;
          m_win[i][1] = (m_c >= 1) ? m_win[i][2] : 8'd0;
        end
        m_win[0][2] = m_top; m_win[1][2] = m_mid; m_win[2][2] = per_img_Y;
      end else begin
        for (int i = 0; i < 3; i++) begin
          for (int j = 0; j < 3; j++) m_win[i][j] = 8'd0;
        end
      end
      pend_win = m_win; pend_href = per_img_href; pend_vs = per_img_vsync;
      if (per_img_vsync && !m_vs_prev) begin
        m_row = 0; m_synced = 1'b1;
      end else if (m_synced && m_href_prev && !per_img_href && m_row < V - 1) begin
        m_row = m_row + 1;
      end
      m_href_prev = per_img_href; m_vs_prev = per_img_vsync;
    end
  endtask

  task automatic check_lit(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gp(input logic [71:0] v, input int i, input int j);
    int k;
    k = (i - 1) * 3 + (j - 1);
    return v[71 - 8 * k -: 8];
  endfunction

  // Pixel (i,j) of the window captured at the idx-th valid output of the last line.
  task automatic chk_pix(input string name, input int idx, input int i, input int j, input int exp);
    logic [7:0] act;
    act = 8'bx;
    if (idx < cap_q.size()) act = gp(cap_q[idx], i, j);
    check_lit(name, {72'd0, act}, 80'(exp));
  endtask

  task automatic drive(input logic vs, input logic hr, input logic [7:0] y);
    @(posedge sys_clk);
    #1;
    per_img_vsync = vs; per_img_href = hr; per_img_Y = y;
  endtask

  task automatic vsync_pulse();
    drive(1'b1, 1'b0, 8'd0); drive(1'b1, 1'b0, 8'd0);
    drive(1'b0, 1'b0, 8'd0); drive(1'b0, 1'b0, 8'd0);
  endtask

  task automatic send_line(input int base, input int step, input int n);
    cap_q.delete();
    for (int k = 0; k < n; k++) drive(1'b0, 1'b1, 8'(base + step * k));
    for (int k = 0; k < 5; k++) drive(1'b0, 1'b0, 8'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_err = 0; ncyc = 0; in_rise = 0; out_rise = 0;
    in_prev = 1'b0; out_prev = 1'b0;
    fork
      forever begin
        @(posedge sys_clk or posedge sys_rst);
        model_step();
      end
      forever begin
        @(negedge sys_clk);
        ncyc++;
        if (per_img_href && !in_prev) in_rise = ncyc;
        in_prev = per_img_href;
        if (matrix_img_href && !out_prev) out_rise = ncyc;
        out_prev = matrix_img_href;
        if (matrix_img_href) cap_q.push_back(dut_pix);
        n_cmp++;
        if (dut_vec !== exp_vec) begin
          n_err++;
          $display("FAIL stream cyc=%0d got=%h expected=%h", ncyc, dut_vec, exp_vec);
        end
      end
    join_none

    repeat (3) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    drive(1'b0, 1'b0, 8'd0);
    #2 check_lit("reset_outputs", {6'd0, dut_vec}, 80'd0);

    // Latency and left border: Y = column index.
    vsync_pulse();
    send_line(0, 1, H);
    check_lit("latency", 80'(out_rise - in_rise), 80'd2);
    check_lit("lat_len", 80'(cap_q.size()), 80'd8);
    for (int c = 0; c < H; c++) chk_pix("lat_p33", c, 3, 3, c);
    chk_pix("lat_c0_p31", 0, 3, 1, 0);
    chk_pix("lat_c0_p32", 0, 3, 2, 0);
    chk_pix("lat_c2_p31", 2, 3, 1, 0);
    chk_pix("lat_c2_p32", 2, 3, 2, 1);
    chk_pix("lat_c2_p33", 2, 3, 3, 2);

    // Row fill with constant lines and 5-cycle gaps; row saturates at V-1.
    vsync_pulse();
    send_line(10, 0, H);
    chk_pix("l0_p13", 3, 1, 3, 0);
    chk_pix("l0_p23", 3, 2, 3, 0);
    chk_pix("l0_p33", 3, 3, 3, 10);
    chk_pix("l0_p31", 3, 3, 1, 10);
    send_line(20, 0, H);
    check_lit("l1_len", 80'(cap_q.size()), 80'd8);
    chk_pix("l1_p13", 3, 1, 3, 0);
    chk_pix("l1_p23", 3, 2, 3, 10);
    chk_pix("l1_p33", 3, 3, 3, 20);
    send_line(30, 0, H);
    chk_pix("l2_c0_p11", 0, 1, 1, 0);
    chk_pix("l2_c0_p13", 0, 1, 3, 10);
    chk_pix("l2_c4_p11", 4, 1, 1, 10);
    chk_pix("l2_c4_p21", 4, 2, 1, 20);
    chk_pix("l2_c4_p31", 4, 3, 1, 30);
    send_line(40, 0, H);
    chk_pix("l3_p13", 5, 1, 3, 20);
    send_line(50, 0, H);
    chk_pix("l4_p13", 5, 1, 3, 30);
    chk_pix("l4_p23", 5, 2, 3, 40);

    // Frame restart masks stale line-buffer contents.
    vsync_pulse();
    send_line(55, 0, H);
    chk_pix("fr_p13", 5, 1, 3, 0);
    chk_pix("fr_p23", 5, 2, 3, 0);
    chk_pix("fr_p11", 5, 1, 1, 0);
    chk_pix("fr_p33", 5, 3, 3, 55);

    // Over-length line: extra pixels reach p33 but not the line buffers.
    send_line(100, 1, H + 3);
    check_lit("ov_len", 80'(cap_q.size()), 80'd11);
    chk_pix("ov_p33_8", 8, 3, 3, 108);
    chk_pix("ov_p33_10", 10, 3, 3, 110);
    chk_pix("ov_p32_9", 9, 3, 2, 108);
    send_line(200, 1, H);
    for (int c = 0; c < H; c++) chk_pix("ov_next_p23", c, 2, 3, 100 + c);
    chk_pix("ov_next_p13", 7, 1, 3, 55);

    // Reset in the middle of a line, then lines without a vsync edge.
    for (int k = 0; k < 4; k++) drive(1'b0, 1'b1, 8'd9);
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b1; per_img_href = 1'b0; per_img_Y = 8'd0;
    #2 check_lit("midline_reset", {6'd0, dut_vec}, 80'd0);
    drive(1'b0, 1'b0, 8'd0); drive(1'b0, 1'b0, 8'd0);
    @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    drive(1'b0, 1'b0, 8'd0); drive(1'b0, 1'b0, 8'd0);
    send_line(77, 0, H);
    chk_pix("rs_p13", 4, 1, 3, 0);
    chk_pix("rs_p23", 4, 2, 3, 0);
    chk_pix("rs_p33", 4, 3, 3, 77);
    send_line(88, 0, H);
    chk_pix("rs2_p23", 4, 2, 3, 0);
    chk_pix("rs2_p33", 4, 3, 3, 88);

    repeat (3) @(posedge sys_clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/y_matrix_3x3.md
Name: y_matrix_3x3

Overview:
- Streaming 3x3 neighbourhood generator for the 8-bit luma plane.
- Sits directly downstream of the RGB-to-YCbCr stage and consumes its post_img_vsync, post_img_href and post_img_Y outputs.
- Produces a registered 3x3 Y window, plus delayed sync, for the following filter stages (median, Sobel, erosion/dilation).
- Uses two line buffers, column and row counters, and border masking.

Parameters:
- IMG_HDISP, 640, active pixels per line; also the line-buffer depth.
- IMG_VDISP, 480, active lines per frame; the row counter saturates at IMG_VDISP-1.

Ports:
- sys_clk  in  1  pixel clock; all logic is on the rising edge.
- sys_rst  in  1  asynchronous, active-high reset.
- per_img_vsync  in  1  frame sync from the YCbCr stage.
- per_img_href  in  1  line-valid from the YCbCr stage; one pixel per cycle while high.
- per_img_Y  in  8  luma pixel.
- matrix_img_vsync  out  1  per_img_vsync delayed by 2 cycles.
- matrix_img_href  out  1  per_img_href delayed by 2 cycles.
- matrix_p11, matrix_p12, matrix_p13  out  8 each  top row of the window (line N-2), oldest column first.
- matrix_p21, matrix_p22, matrix_p23  out  8 each  middle row (line N-1).
- matrix_p31, matrix_p32, matrix_p33  out  8 each  bottom row (line N, the current line); p33 is the newest pixel.

Behaviour:
- Reset: asynchronous, active-high on sys_rst.
  - All outputs go to 0; the column counter, row counter and delay registers go to 0.
  - Line-buffer RAM contents are not reset; the row mask hides them.
- Latency: the pixel sampled with href=1 at cycle t appears on matrix_p33 at t+2, with matrix_img_href=1 at t+2.
- Window anchoring: the window is bottom-right anchored. For input pixel (row r, col c):
  - pij = Y(r-3+i, c-3+j).
  - Example: p33 = Y(r,c), p31 = Y(r,c-2), p13 = Y(r-2,c).
- Column counter col:
  - 0 on the first href-high cycle of a line.
  - Increments each href-high cycle.
  - Saturates at IMG_HDISP-1; pixels past that point pass to p33 but are not written to the line buffers.
- Row counter row:
  - Cleared on the rising edge of per_img_vsync.
  - Increments on each falling edge of per_img_href.
  - Saturates at IMG_VDISP-1.
- Line buffers: two RAMs, buf1 (holds line N-1) and buf2 (holds line N-2), each IMG_HDISP x 8.
  - At each href-high cycle, read buf1[col] and buf2[col]; the read data is valid at t+1.
  - In the same cycle, write buf1[col]<=per_img_Y and buf2[col]<=old buf1[col], forwarding the RAM read-out.
  - Read-before-write on the same address is required.
- Column stage (t+1): registers colv = {buf2_q, buf1_q, Y_d1}.
  - buf2_q is forced to 0 when the pixel's row < 2.
  - buf1_q is forced to 0 when row < 1.
- Window stage (t+2): while the delayed href is 1, the window shifts left by one column and colv loads into the p13/p23/p33 column.
  - Columns p*1 are forced to 0 when the pixel's col < 2.
  - Columns p*2 are forced to 0 when col < 1.
  - While the delayed href is 0, all nine pixel outputs are 0 and the window contents clear.
- Border rule: missing neighbours are always 0 (zero padding); they are never replicated.
- Simultaneous events:
  - A vsync rising edge in the same cycle as an href falling edge: the row counter clears and does not increment.
  - An href pulse during vsync high is processed normally.
- Reset mid-frame:
  - Outputs go to 0 immediately.
  - After release, the row counter stays at 0 until a vsync rising edge, so lines processed before that edge are treated as top-border lines.
- Width rules: col is clog2(IMG_HDISP) bits and row is clog2(IMG_VDISP) bits; all pixel paths are 8-bit with no arithmetic.

Decomposition:
- Shared package img_pkg holds:
  - PIX_W = 8.
  - Default IMG_HDISP and IMG_VDISP.
  - A pixel typedef pix_t (8-bit).
- One sub-module, line_buffer_ram: simple dual-port RAM with parameterised depth, 1-cycle registered read and read-before-write.
  - Instantiated twice, for buf1 and buf2.

Test Plan:
- Reset: assert sys_rst mid-line -> all nine matrix outputs, matrix_img_href and matrix_img_vsync read 0 in the same cycle. After release with no vsync edge, the first line shows p1x = p2x = 0.
- Latency: one vsync pulse, then a line of Y = col index (0..7) with IMG_HDISP=8 -> matrix_img_href high exactly 2 cycles after per_img_href. p33 sequence is 0..7; at col 0, p31 = p32 = 0; at col 2, p31=0, p32=1, p33=2.
- Row fill: after a vsync pulse, send three lines of constant value 10, 20, 30:
  - Line 0: p1x = p2x = 0, p3x = 10.
  - Line 1: p2x = 10, p3x = 20.
  - Line 2 at col >= 2: p1x = 10, p2x = 20, p3x = 30.
- Frame restart: after a full frame, send a vsync pulse, then a line of 55 -> p1x = p2x = 0, p3x = 55 (stale RAM data masked).
- Over-length line: href held for IMG_HDISP+3 cycles -> 3 extra pixels appear on p33. The next line's p2x values for col < IMG_HDISP still equal the previous line's first IMG_HDISP pixels.
- Href gaps: 5 idle cycles between lines -> all outputs are 0 during the delayed gap, and the row counter increments exactly once per line.
